// File: rtl/mvma_job_arbiter.sv
// Round-robin job arbiter sharing one MVMA engine between NUM_REQ requesters.
// A job is JOB_WORDS input words followed by RES_WORDS results; the grant is held for the whole job.
module mvma_job_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int JOB_WORDS = 24,
    parameter int RES_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_s_valid,
    input  logic [NUM_REQ*8-1:0]       req_data_in,
    output logic [NUM_REQ-1:0]         req_s_ready,
    output logic [NUM_REQ-1:0]         req_m_valid,
    input  logic [NUM_REQ-1:0]         req_m_ready,
    output logic [15:0]                req_data_out,
    output logic [NUM_REQ-1:0]         req_overflow,
    output logic                       eng_s_valid,
    input  logic                       eng_s_ready,
    output logic [7:0]                 eng_data_in,
    input  logic                       eng_m_valid,
    output logic                       eng_m_ready,
    input  logic [15:0]                eng_data_out,
    input  logic                       eng_overflow,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       job_done,
    output logic                       proto_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IN_W  = (JOB_WORDS > 1) ? $clog2(JOB_WORDS) : 1;
    localparam int OUT_W = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(JOB_WORDS - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(RES_WORDS - 1);

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_grant_id;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [IN_W-1:0]  r_in_cnt;
    logic [OUT_W-1:0] r_out_cnt;
    logic             r_proto_err;
    logic             r_job_done;

    logic               w_load;
    logic               w_drain;
    logic [NUM_REQ-1:0] w_sel;
    logic [7:0]         w_data_mux;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_found;
    logic [ID_W-1:0]    w_win_id;
    logic [ID_W-1:0]    w_next_ptr;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    assign w_load  = (r_state == S_LOAD);
    assign w_drain = (r_state == S_DRAIN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_sel[gi]        = (r_grant_id == ID_W'(gi));
            assign req_s_ready[gi]  = w_load & w_sel[gi] & eng_s_ready;
            assign req_m_valid[gi]  = w_drain & w_sel[gi] & eng_m_valid;
            assign req_overflow[gi] = w_drain & w_sel[gi] & eng_m_valid & eng_overflow;
        end
    endgenerate

    always_comb begin
        w_data_mux = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel[i]) begin
                w_data_mux = req_data_in[i*8 +: 8];
            end
        end
    end

    // Scan starts at the round-robin pointer; the first valid requester after it wins.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_s_valid[wrap_add(r_rr_ptr, k)]) begin
                w_found  = 1'b1;
                w_win_id = wrap_add(r_rr_ptr, k);
            end
        end
    end

    assign w_next_ptr = wrap_add(r_grant_id, 1);

    assign eng_s_valid  = w_load & |(w_sel & req_s_valid);
    assign eng_data_in  = w_load ? w_data_mux : 8'h00;
    assign eng_m_ready  = w_drain & |(w_sel & req_m_ready);
    assign req_data_out = w_drain ? eng_data_out : 16'h0000;

    assign w_in_xfer  = eng_s_valid & eng_s_ready;
    assign w_out_xfer = eng_m_valid & eng_m_ready;

    assign grant_id  = r_grant_id;
    assign busy      = w_load | w_drain;
    assign job_done  = r_job_done;
    assign proto_err = r_proto_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_proto_err <= 1'b0;
            r_job_done  <= 1'b0;
        end else begin
            r_job_done <= 1'b0;
            // A result offered while we are not draining has nowhere to go.
            if (eng_m_valid && !w_drain) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_win_id;
                        r_in_cnt   <= '0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_in_xfer) begin
                        if (r_in_cnt == IN_LAST) begin
                            r_in_cnt  <= '0;
                            r_out_cnt <= '0;
                            r_state   <= S_DRAIN;
                        end else begin
                            r_in_cnt <= r_in_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_xfer) begin
                        if (r_out_cnt == OUT_LAST) begin
                            r_out_cnt  <= '0;
                            r_job_done <= 1'b1;
                            r_rr_ptr   <= w_next_ptr;
                            r_state    <= S_IDLE;
                        end else begin
                            r_out_cnt <= r_out_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvma_job_arbiter.sv
// Bench for mvma_job_arbiter: plays both the requesters and the engine, with a scoreboard
// of input words per requester and of engine results tagged with the owning requester.
module tb_mvma_job_arbiter;

    localparam int NUM_REQ = 2;
    localparam int JOB     = 24;
    localparam int RES     = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_s_valid;
    logic [NUM_REQ*8-1:0] req_data_in;
    logic [NUM_REQ-1:0]   req_s_ready;
    logic [NUM_REQ-1:0]   req_m_valid;
    logic [NUM_REQ-1:0]   req_m_ready;
    logic [15:0]          req_data_out;
    logic [NUM_REQ-1:0]   req_overflow;
    logic                 eng_s_valid;
    logic                 eng_s_ready;
    logic [7:0]           eng_data_in;
    logic                 eng_m_valid;
    logic                 eng_m_ready;
    logic [15:0]          eng_data_out;
    logic                 eng_overflow;
    logic [0:0]           grant_id;
    logic                 busy;
    logic                 job_done;
    logic                 proto_err;

    always #5 clk = ~clk;

    mvma_job_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .JOB_WORDS(JOB),
        .RES_WORDS(RES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_s_valid (req_s_valid),
        .req_data_in (req_data_in),
        .req_s_ready (req_s_ready),
        .req_m_valid (req_m_valid),
        .req_m_ready (req_m_ready),
        .req_data_out(req_data_out),
        .req_overflow(req_overflow),
        .eng_s_valid (eng_s_valid),
        .eng_s_ready (eng_s_ready),
        .eng_data_in (eng_data_in),
        .eng_m_valid (eng_m_valid),
        .eng_m_ready (eng_m_ready),
        .eng_data_out(eng_data_out),
        .eng_overflow(eng_overflow),
        .grant_id    (grant_id),
        .busy        (busy),
        .job_done    (job_done),
        .proto_err   (proto_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]         src_q [NUM_REQ][$];
    logic [NUM_REQ-1:0] src_en;
    logic [16:0]        res_plan[$];
    logic [16:0]        eng_out_q[$];
    int                 owner_q[$];
    int                 job_log[$];
    int                 eng_rx;
    int                 req_in_cnt[NUM_REQ];
    int                 res_cnt[NUM_REQ];
    int                 eng_in_total;
    int                 eng_res_total;
    int                 job_done_cnt;
    bit                 srdy_toggle;
    bit                 mstall;
    bit                 force_mv;

    task automatic drive_inputs();
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_en[i] && src_q[i].size() > 0) begin
                req_s_valid[i]         = 1'b1;
                req_data_in[i*8 +: 8]  = src_q[i][0];
            end else begin
                req_s_valid[i]         = 1'b0;
                req_data_in[i*8 +: 8]  = 8'h00;
            end
        end
        eng_s_ready = srdy_toggle ? ((cyc % 2) == 1) : 1'b1;
        eng_m_valid = force_mv || (eng_out_q.size() > 0);
        if (eng_out_q.size() > 0) begin
            eng_data_out = eng_out_q[0][15:0];
            eng_overflow = eng_out_q[0][16];
        end else begin
            eng_data_out = 16'h0000;
            eng_overflow = 1'b0;
        end
        req_m_ready = {NUM_REQ{mstall ? ((cyc % 4) == 3) : 1'b1}};
    endtask

    // Scoreboard update at the falling edge: every handshake seen here completes at the next rising edge.
    task automatic sample();
        logic [7:0]  exp_b;
        logic [16:0] exp_r;
        checks++;
        if ($countones(req_s_ready) > 1) begin
            errors++;
            $display("FAIL one_ready: got req_s_ready=%b expected at most one bit", req_s_ready);
        end
        checks++;
        if ((req_overflow & ~req_m_valid) != '0) begin
            errors++;
            $display("FAIL ovf_qual: got req_overflow=%b with req_m_valid=%b", req_overflow, req_m_valid);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_s_valid[i] && req_s_ready[i]) begin
                exp_b = src_q[i].pop_front();
                checks++;
                if (eng_s_valid !== 1'b1 || eng_data_in !== exp_b) begin
                    errors++;
                    $display("FAIL in_word req%0d: got valid=%0b data=%02h expected valid=1 data=%02h",
                             i, eng_s_valid, eng_data_in, exp_b);
                end
                req_in_cnt[i]++;
                eng_rx++;
                if (eng_rx == JOB) begin
                    eng_rx = 0;
                    job_log.push_back(i);
                    for (int k = 0; k < RES; k++) begin
                        if (res_plan.size() > 0) begin
                            eng_out_q.push_back(res_plan.pop_front());
                            owner_q.push_back(i);
                        end
                    end
                end
            end
        end
        if (eng_s_valid && eng_s_ready) eng_in_total++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_m_valid[i] && req_m_ready[i]) begin
                checks++;
                if (eng_out_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result req%0d: got data=%04h expected no result", i, req_data_out);
                end else begin
                    exp_r = eng_out_q[0];
                    if (owner_q[0] != i || req_data_out !== exp_r[15:0] || req_overflow[i] !== exp_r[16]) begin
                        errors++;
                        $display("FAIL result req%0d: got data=%04h ovf=%0b expected req%0d data=%04h ovf=%0b",
                                 i, req_data_out, req_overflow[i], owner_q[0], exp_r[15:0], exp_r[16]);
                    end
                end
                res_cnt[i]++;
            end
        end
        if (eng_m_valid && eng_m_ready) begin
            eng_res_total++;
            if (eng_out_q.size() > 0) begin
                exp_r = eng_out_q.pop_front();
                void'(owner_q.pop_front());
            end
        end
        if (job_done) job_done_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        sample();
    endtask

    task automatic wait_jobs(input int target, input int budget, input string name);
        for (int n = 0; n < budget && job_done_cnt < target; n++) tick();
        checks++;
        if (job_done_cnt < target) begin
            errors++;
            $display("FAIL %s timeout: got job_done count %0d expected %0d", name, job_done_cnt, target);
        end
    endtask

    task automatic push_job(input int r, input int base);
        for (int k = 0; k < JOB; k++) src_q[r].push_back(8'(base + 7 * k));
    endtask

    task automatic push_res(input int data, input bit ovf);
        res_plan.push_back({ovf, 16'(data)});
    endtask

    task automatic clear_bench();
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        res_plan.delete();
        eng_out_q.delete();
        owner_q.delete();
        eng_rx      = 0;
        src_en      = '0;
        srdy_toggle = 1'b0;
        mstall      = 1'b0;
        force_mv    = 1'b0;
        drive_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_bench();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int b_in;
        int b_res;
        reset = 1'b1;
        clear_bench();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, job_done, proto_err, grant_id} !== 4'b0 || req_s_ready !== '0 || req_m_valid !== '0 ||
            eng_s_valid !== 1'b0 || eng_m_ready !== 1'b0 || req_overflow !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b done=%0b perr=%0b gid=%0d srdy=%b mval=%b esv=%0b emr=%0b expected all 0",
                     busy, job_done, proto_err, grant_id, req_s_ready, req_m_valid, eng_s_valid, eng_m_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        push_job(0, 8'h20);
        src_en[0] = 1'b1;
        for (int n = 0; n < 100 && req_in_cnt[0] < 10; n++) tick();
        checks++;
        if (req_in_cnt[0] != 10) begin
            errors++;
            $display("FAIL midload_words: got %0d words expected 10", req_in_cnt[0]);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || req_s_ready !== '0 || eng_s_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got busy=%0b srdy=%b esv=%0b expected 0 0 0", busy, req_s_ready, eng_s_valid);
        end
        clear_bench();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        b_in  = req_in_cnt[0];
        b_res = res_cnt[0];
        push_job(0, 8'h40);
        push_res(11, 1'b0); push_res(22, 1'b0); push_res(33, 1'b0); push_res(44, 1'b0);
        src_en[0] = 1'b1;
        wait_jobs(job_done_cnt + 1, 200, "reload_job");
        checks++;
        if (req_in_cnt[0] - b_in != JOB || res_cnt[0] - b_res != RES) begin
            errors++;
            $display("FAIL reload_counts: got in=%0d res=%0d expected in=%0d res=%0d",
                     req_in_cnt[0] - b_in, res_cnt[0] - b_res, JOB, RES);
        end
        repeat (2) tick();
    endtask

    task automatic test_single_job();
        int b_done;
        int b_res0;
        int b_res1;
        src_en  = '0;
        b_done  = job_done_cnt;
        b_res0  = res_cnt[0];
        b_res1  = res_cnt[1];
        push_job(0, 8'h05);
        push_res(100, 1'b0); push_res(-5, 1'b0); push_res(32767, 1'b1); push_res(0, 1'b0);
        src_en[0] = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL grant_latency_idle: got busy=%0b expected 0", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || grant_id !== 1'b0 || req_s_ready !== 2'b01) begin
            errors++;
            $display("FAIL grant_latency_load: got busy=%0b gid=%0d srdy=%b expected 1 0 01", busy, grant_id, req_s_ready);
        end
        wait_jobs(b_done + 1, 200, "single_job");
        repeat (3) tick();
        checks++;
        if (job_done_cnt - b_done != 1) begin
            errors++;
            $display("FAIL job_done_pulse: got %0d high cycles expected 1", job_done_cnt - b_done);
        end
        checks++;
        if (res_cnt[0] - b_res0 != RES || res_cnt[1] != b_res1) begin
            errors++;
            $display("FAIL single_results: got req0=%0d req1=%0d expected req0=%0d req1=0",
                     res_cnt[0] - b_res0, res_cnt[1] - b_res1, RES);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_clean: got proto_err=%0b expected 0", proto_err);
        end
    endtask

    task automatic test_contention();
        int b_done;
        int b_log;
        do_reset();
        b_done = job_done_cnt;
        b_log  = job_log.size();
        push_job(0, 8'h10);
        push_job(0, 8'h90);
        push_job(1, 8'h33);
        for (int k = 0; k < 3 * RES; k++) push_res(1000 + k, (k % 5) == 2);
        src_en = '1;
        wait_jobs(b_done + 1, 200, "contention_job1");
        tick();
        checks++;
        if (busy !== 1'b1 || grant_id !== 1'b1) begin
            errors++;
            $display("FAIL regrant: got busy=%0b gid=%0d expected busy=1 gid=1", busy, grant_id);
        end
        wait_jobs(b_done + 3, 400, "contention_jobs");
        checks++;
        if (job_log.size() != b_log + 3 || job_log[b_log] != 0 || job_log[b_log+1] != 1 || job_log[b_log+2] != 0) begin
            errors++;
            $display("FAIL rr_order: got %0d jobs first owner %0d expected 3 jobs order 0,1,0",
                     job_log.size() - b_log, (job_log.size() > b_log) ? job_log[b_log] : -1);
        end
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        int b_in;
        int b_res;
        int b_r1;
        src_en      = '0;
        srdy_toggle = 1'b1;
        mstall      = 1'b1;
        b_in  = eng_in_total;
        b_res = eng_res_total;
        b_r1  = res_cnt[1];
        push_job(1, 8'hA1);
        push_res(-300, 1'b1); push_res(7, 1'b0); push_res(-32768, 1'b0); push_res(512, 1'b1);
        src_en[1] = 1'b1;
        wait_jobs(job_done_cnt + 1, 500, "backpressure");
        checks++;
        if (eng_in_total - b_in != JOB || eng_res_total - b_res != RES || res_cnt[1] - b_r1 != RES || src_q[1].size() != 0) begin
            errors++;
            $display("FAIL bp_counts: got in=%0d res=%0d req1=%0d left=%0d expected in=%0d res=%0d req1=%0d left=0",
                     eng_in_total - b_in, eng_res_total - b_res, res_cnt[1] - b_r1, src_q[1].size(), JOB, RES, RES);
        end
        srdy_toggle = 1'b0;
        mstall      = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_isolation();
        int b_done;
        int b_in1;
        logic [7:0] first1;
        src_en = '0;
        b_done = job_done_cnt;
        b_in1  = req_in_cnt[1];
        push_job(0, 8'h61);
        push_job(1, 8'hC4);
        first1 = src_q[1][0];
        for (int k = 0; k < 2 * RES; k++) push_res(-k * 9, 1'b0);
        src_en = '1;
        for (int n = 0; n < 200 && job_done_cnt < b_done + 1; n++) begin
            tick();
            checks++;
            if (req_s_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL isolation: got req_s_ready[1]=%0b during req0 job expected 0", req_s_ready[1]);
            end
        end
        tick();
        checks++;
        if (grant_id !== 1'b1 || req_s_ready[1] !== 1'b1 || eng_data_in !== first1) begin
            errors++;
            $display("FAIL first_word: got gid=%0d srdy1=%0b data=%02h expected 1 1 %02h",
                     grant_id, req_s_ready[1], eng_data_in, first1);
        end
        wait_jobs(b_done + 2, 200, "isolation");
        checks++;
        if (req_in_cnt[1] - b_in1 != JOB) begin
            errors++;
            $display("FAIL iso_words: got %0d expected %0d", req_in_cnt[1] - b_in1, JOB);
        end
        repeat (2) tick();
    endtask

    task automatic test_proto_err();
        int b_in;
        int b_res;
        src_en = '0;
        b_in   = req_in_cnt[0];
        b_res  = res_cnt[0];
        push_job(0, 8'h7E);
        push_res(1, 1'b0); push_res(2, 1'b0); push_res(3, 1'b0); push_res(4, 1'b0);
        src_en[0] = 1'b1;
        for (int n = 0; n < 100 && req_in_cnt[0] - b_in < 5; n++) tick();
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_before: got proto_err=%0b expected 0", proto_err);
        end
        force_mv = 1'b1;
        tick();
        checks++;
        if (req_m_valid !== '0 || eng_m_ready !== 1'b0) begin
            errors++;
            $display("FAIL proto_mvalid: got req_m_valid=%b eng_m_ready=%0b expected 00 0", req_m_valid, eng_m_ready);
        end
        force_mv = 1'b0;
        tick();
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_set: got proto_err=%0b expected 1", proto_err);
        end
        wait_jobs(job_done_cnt + 1, 200, "proto_job");
        checks++;
        if (proto_err !== 1'b1 || res_cnt[0] - b_res != RES) begin
            errors++;
            $display("FAIL proto_sticky: got proto_err=%0b res=%0d expected 1 %0d", proto_err, res_cnt[0] - b_res, RES);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_clear: got proto_err=%0b expected 0", proto_err);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_in_cnt[i] = 0;
            res_cnt[i]    = 0;
        end
        eng_in_total  = 0;
        eng_res_total = 0;
        job_done_cnt  = 0;
        test_reset();
        test_single_job();
        test_contention();
        test_backpressure();
        test_isolation();
        test_proto_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mvma_job_arbiter.md
# mvma_job_arbiter

Round-robin job scheduler that shares one matrix-vector engine (the part-3 MVMA datapath: 8-bit input stream, 16-bit result stream with overflow) between NUM_REQ requesters. A job is one complete input load (A, then X, then B) followed by draining all results. The block grants the engine to one requester per job, muxes that requester's input stream in, routes the result stream back to it, and holds off every other requester until the job completes.

## Interface
- NUM_REQ, default 2: number of requesters (2..8).
- JOB_WORDS, default 24: input words per job (A 16 + X 4 + B 4).
- RES_WORDS, default 4: result words per job (one per A row).
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req_s_valid  input  NUM_REQ  per-requester input word valid.
- req_data_in  input  NUM_REQ*8  per-requester signed input word; requester i at bits [8i+7:8i].
- req_s_ready  output  NUM_REQ  per-requester input accept.
- req_m_valid  output  NUM_REQ  per-requester result valid.
- req_m_ready  input  NUM_REQ  per-requester result accept.
- req_data_out  output  16  engine result, broadcast to all requesters (qualify with req_m_valid).
- req_overflow  output  NUM_REQ  engine overflow, asserted only on the granted requester's bit alongside req_m_valid.
- eng_s_valid / eng_s_ready / eng_data_in  output / input / output  1/1/8  engine input stream.
- eng_m_valid / eng_m_ready / eng_data_out / eng_overflow  input / output / input / input  1/1/16/1  engine result stream.
- grant_id  output  clog2(NUM_REQ)  current/last granted requester.
- busy  output  1  high in LOAD or DRAIN.
- job_done  output  1  one-cycle pulse on acceptance of a job's last result.
- proto_err  output  1  sticky: eng_m_valid seen outside DRAIN.

## Operation
- FSM states IDLE, LOAD, DRAIN. Registers: state, grant_id, rr_ptr, in_cnt (0..JOB_WORDS-1), out_cnt (0..RES_WORDS-1), proto_err, job_done.
- IDLE: scan req_s_valid starting at rr_ptr, wrapping mod NUM_REQ; first set bit wins. On a win: grant_id <= winner, in_cnt <= 0, state <= LOAD. No input is accepted in IDLE (all req_s_ready 0).
- LOAD: eng_s_valid = req_s_valid[grant_id]; eng_data_in = req_data_in[grant_id]; req_s_ready[grant_id] = eng_s_ready; other req_s_ready 0. A transfer is eng_s_valid & eng_s_ready; each increments in_cnt. Transfer with in_cnt == JOB_WORDS-1: out_cnt <= 0, state <= DRAIN.
- DRAIN: req_m_valid[grant_id] = eng_m_valid; req_overflow[grant_id] = eng_m_valid & eng_overflow; eng_m_ready = req_m_ready[grant_id]; other requesters see 0. Each eng_m_valid & eng_m_ready increments out_cnt. On the accept with out_cnt == RES_WORDS-1: job_done <= 1 (next cycle only), rr_ptr <= (grant_id+1) mod NUM_REQ, state <= IDLE.
- Outside LOAD: eng_s_valid 0. Outside DRAIN: eng_m_ready 0, all req_m_valid 0; eng_m_valid high sets proto_err (sticky until reset).
- A granted requester that stalls (s_valid low, m_ready low) holds the engine indefinitely; no timeout.

## Timing
- Reset values: state IDLE, grant_id 0, rr_ptr 0, in_cnt 0, out_cnt 0, busy 0, job_done 0, proto_err 0; all combinational outputs therefore 0. Reset asserted mid-job returns to IDLE immediately; the engine shares the same reset and is cleared with it.
- Grant latency: req_s_valid seen in IDLE at cycle N -> LOAD at N+1 -> earliest first transfer at N+1.
- Input and result paths are combinational pass-through, zero added latency; no buffering.
- Last result accepted at cycle M -> job_done high and state IDLE at M+1 -> earliest next grant decision at M+1, LOAD at M+2.
- Simultaneous requests resolve purely by rr_ptr; requests that drop before IDLE samples them are not remembered.

## Test plan
- Reset: assert reset mid-LOAD after 10 words -> busy, req_s_ready, eng_s_valid 0 immediately; after release, req0 job of 24 words loads from in_cnt 0.
- Single job: req0 sends 24 words, engine returns 4 results (e.g. 100, -5, 32767, 0 with overflow on third) -> req_m_valid[0] four times, req_overflow[0] only on third, job_done one pulse, req1 sees nothing.
- Contention: req0 and req1 both valid from reset -> req0 granted first; after its job_done, req1 granted at the following cycle; third job goes back to req0.
- Backpressure: eng_s_ready toggling 1/0 and req_m_ready low for 3 cycles per result -> exactly 24 input transfers and 4 result transfers counted; no duplicate or dropped words.
- Isolation: req1 asserts s_valid throughout req0's job -> req_s_ready[1] stays 0 until req1 is granted; its first word then is the first word delivered.
- Protocol error: pulse eng_m_valid during LOAD -> proto_err 1 and stays 1 until reset; no req_m_valid asserted.
